tx_stream_arbiter: RTL and testbench

- Shares one phase-1 transmitter pipeline (fraction-to-fixed stage followed by the CORDIC transmit pipeline) among NREQ requesters.
- Grants one 32-bit request per cycle, round-robin. Drives the pipeline's input_valid, enable and input_num.
- Tracks each in-flight sample's source through a tag shift register matched to the pipeline latency. Returns each result tagged with its source.
- Sits between the per-channel sample producers and the transmitter instance.

---
 rtl/tx_pkg.sv | 19 +
 rtl/tx_tag_pipe.sv | 17 +
 rtl/tx_stream_arbiter.sv | 109 ++++++++++
 tb/tb_tx_stream_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// tx_pkg: shared constants for the transmit stream arbiter and tag pipelines.
package tx_pkg;
  localparam int NPIPE = 13;
  localparam int LAT_DEF = NPIPE + 2;
  localparam int NREQ_DEF = 4;
  localparam int DW = 32;
  function automatic int srcw_f(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction
  localparam int SRCW_DEF = srcw_f(NREQ_DEF);
  // Tag layout: valid in the MSB, source index below it.
  typedef struct packed {
    logic                valid;
    logic [SRCW_DEF-1:0] src;
  } tag_t;
  function automatic int tag_w(input int srcw);
    return srcw + 1;
  endfunction
endpackage

// File: rtl/tx_tag_pipe.sv
// tx_tag_pipe: LAT-deep tag shift register with enable, async active-low reset.
module tx_tag_pipe #(
  parameter int LAT = 15,
  parameter int W   = 3
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [LAT*W-1:0] r_sr;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_sr <= '0;
    else if (i_en) r_sr <= {r_sr[(LAT-1)*W-1:0], i_d};
  assign o_q = r_sr[LAT*W-1 -: W];
endmodule

// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter: round-robin sharing of one transmitter pipeline, results tagged by source.
// Define TX_ARB_PRIORITY_EN to give requester 0 strict priority over the rotating others.
module tx_stream_arbiter
  import tx_pkg::*;
#(
  parameter int n    = 16,
  parameter int NREQ = NREQ_DEF,
  parameter int SRCW = srcw_f(NREQ),
  parameter int LAT  = LAT_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               stall,
  output logic               tx_input_valid,
  output logic               tx_enable,
  output logic [DW-1:0]      tx_input_num,
  input  logic               tx_output_valid,
  input  logic [n-1:0]       tx_output_num,
  output logic               out_valid,
  output logic [n-1:0]       out_num,
  output logic [SRCW-1:0]    out_src,
  output logic [SRCW+3:0]    inflight,
  output logic               err_mismatch
);
  localparam int TW = tag_w(SRCW);
  logic [SRCW-1:0] r_ptr, r_src, r_os, w_idx, w_nptr;
  logic            r_iv, r_ov, r_err, w_any, w_upd;
  logic [DW-1:0]   r_num, w_data;
  logic [n-1:0]    r_on;
  logic [SRCW+3:0] r_infl;
  logic [TW-1:0]   w_tag;
  int              w_j;
  // Reverse scan so the last hit is the first requester at or above the pointer.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = (int'(r_ptr) + k) % NREQ;
`ifdef TX_ARB_PRIORITY_EN
      if (req_valid[w_j] && w_j != 0) begin
`else
      if (req_valid[w_j]) begin
`endif
        w_any = 1'b1;
        w_idx = SRCW'(w_j);
      end
    end
`ifdef TX_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      w_any = 1'b1;
      w_idx = '0;
    end
    w_upd = w_any && !stall && !req_valid[0];
`else
    w_upd = w_any && !stall;
`endif
    if (stall) w_any = 1'b0;
  end
  assign req_ready = w_any ? NREQ'(1) << w_idx : '0;
  assign w_data    = req_data[DW*w_idx +: DW];
  assign w_nptr    = (w_idx == SRCW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
  assign tx_enable = ~stall;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_iv  <= 1'b0;
      r_num <= '0;
      r_src <= '0;
      r_ptr <= '0;
    end else if (!stall) begin
      r_iv <= w_any;
      if (w_any) begin
        r_num <= w_data;
        r_src <= w_idx;
      end
      if (w_upd) r_ptr <= w_nptr;
    end
  tx_tag_pipe #(.LAT(LAT), .W(TW)) u_tag (
    .clock (clock),
    .resetn(resetn),
    .i_en  (~stall),
    .i_d   ({r_iv, r_src}),
    .o_q   (w_tag)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_ov   <= 1'b0;
      r_on   <= '0;
      r_os   <= '0;
      r_err  <= 1'b0;
      r_infl <= '0;
    end else if (!stall) begin
      r_ov   <= tx_output_valid & w_tag[TW-1];
      r_on   <= tx_output_num;
      r_os   <= w_tag[SRCW-1:0];
      r_infl <= r_infl + (SRCW+4)'(r_iv) - (SRCW+4)'(w_tag[TW-1]);
      if (tx_output_valid != w_tag[TW-1]) r_err <= 1'b1;
    end
  assign tx_input_valid = r_iv;
  assign tx_input_num   = r_num;
  assign out_valid      = r_ov;
  assign out_num        = r_on;
  assign out_src        = r_os;
  assign inflight       = r_infl;
  assign err_mismatch   = r_err;
endmodule

// File: tb/tb_tx_stream_arbiter.sv
// tb_tx_stream_arbiter: directed checks of grant order, latency, stall, mismatch and reset.
module tb_tx_stream_arbiter;
  localparam int LAT = 15;
  logic         clock = 1'b0, resetn = 1'b0, stall = 1'b0, spur = 1'b0;
  logic [3:0]   req_valid = '0, req_ready;
  logic [127:0] req_data = '0;
  logic         tx_input_valid, tx_enable, tx_output_valid, out_valid, err_mismatch;
  logic [31:0]  tx_input_num;
  logic [15:0]  tx_output_num, out_num;
  logic [1:0]   out_src;
  logic [5:0]   inflight;
  logic [LAT-1:0]    m_v;
  logic [LAT*16-1:0] m_d;
  int checks = 0, errors = 0;

  tx_stream_arbiter dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .stall(stall), .tx_input_valid(tx_input_valid),
    .tx_enable(tx_enable), .tx_input_num(tx_input_num), .tx_output_valid(tx_output_valid),
    .tx_output_num(tx_output_num), .out_valid(out_valid), .out_num(out_num),
    .out_src(out_src), .inflight(inflight), .err_mismatch(err_mismatch)
  );

  always #5 clock = ~clock;

  // Transmitter model: LAT-cycle delay, frozen while enable is low, result = upper half ^ 1234.
  always @(posedge clock or negedge resetn)
    if (!resetn) begin
      m_v <= '0;
      m_d <= '0;
    end else if (tx_enable) begin
      m_v <= {m_v[LAT-2:0], tx_input_valid};
      m_d <= {m_d[(LAT-1)*16-1:0], tx_input_num[31:16] ^ 16'h1234};
    end
  assign tx_output_valid = m_v[LAT-1] | spur;
  assign tx_output_num   = m_d[LAT*16-1 -: 16];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  function automatic int exp_src(input int mode, input int j);
    if (mode == 3) return (j % 2 == 1) ? 2 : 1;
`ifdef TX_ARB_PRIORITY_EN
    return 0;
`else
    return j % 4;
`endif
  endfunction

  function automatic logic [15:0] exp_num(input int mode, input int j);
    logic [15:0] b;
    b = (mode == 3) ? ((j % 2 == 1) ? 16'h0B00 : 16'h0A00) : 16'(16'h0100 * exp_src(mode, j));
    return (b + 16'(j)) ^ 16'h1234;
  endfunction

  task automatic collect(input int mode, input int nexp);
    int cnt = 0, last = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        if (cnt > 0) chk("consecutive", 32'(c), 32'(last + 1));
        chk("res_src", 32'(out_src), 32'(exp_src(mode, cnt)));
        chk("res_num", 32'(out_num), 32'(exp_num(mode, cnt)));
        last = c;
        cnt++;
      end
      tick();
    end
    chk("result_count", 32'(cnt), 32'(nexp));
  endtask

  initial begin
    int first, pulses, peak;
    logic [1:0] fsrc;
    logic [15:0] fnum;
    logic [3:0] g6 [8];
    #1;
    chk("rst_in_valid", 32'(tx_input_valid), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_err", 32'(err_mismatch), 0);
    chk("rst_ready", 32'(req_ready), 0);
    tick();
    resetn = 1'b1;
    tick();
    // Single request: grant, issue, and result at cycle 17.
    req_valid = 4'b0001;
    req_data[31:0] = 32'h3F000000;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_enable", 32'(tx_enable), 1);
    tick();
    req_valid = '0;
    #1;
    chk("t1_in_valid", 32'(tx_input_valid), 1);
    chk("t1_in_num", tx_input_num, 32'h3F000000);
    chk("t1_ready_off", 32'(req_ready), 0);
    first = 0; pulses = 0; peak = 0; fsrc = '1; fnum = '0;
    for (int c = 1; c <= 40; c++) begin
      if (out_valid) begin
        pulses++;
        if (first == 0) begin
          first = c;
          fsrc = out_src;
          fnum = out_num;
        end
      end
      if (int'(inflight) > peak) peak = int'(inflight);
      tick();
      if (c < 40) #0;
    end
    chk("t1_latency", 32'(first), 17);
    chk("t1_src", 32'(fsrc), 0);
    chk("t1_num", 32'(fnum), 32'h2D34);
    chk("t1_pulses", 32'(pulses), 1);
    chk("t1_peak", 32'(peak), 1);
    chk("t1_inflight_end", 32'(inflight), 0);
    // All four requesters for 8 cycles from a fresh pointer.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) req_data[32*i +: 32] = {16'(16'h0100 * i + k), 16'h0};
      #1;
      chk("t2_grant", 32'(req_ready), 32'(4'b0001 << exp_src(2, k)));
      tick();
    end
    req_valid = '0;
    collect(2, 8);
    chk("t2_err", 32'(err_mismatch), 0);
    // Stall five cycles mid-burst with requesters 1 and 2 alternating.
    for (int k = 0; k < 8; k++) begin
      req_valid = 4'b0110;
      req_data[63:32] = {16'(16'h0A00 + k), 16'h0};
      req_data[95:64] = {16'(16'h0B00 + k), 16'h0};
      #1;
      chk("t3_grant", 32'(req_ready), (k % 2 == 1) ? 32'h4 : 32'h2);
      tick();
      if (k == 3) begin
        stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
          #1;
          chk("t3_stall_ready", 32'(req_ready), 0);
          chk("t3_stall_enable", 32'(tx_enable), 0);
          chk("t3_stall_inflight", 32'(inflight), 3);
          chk("t3_stall_in_valid", 32'(tx_input_valid), 1);
          chk("t3_stall_in_num", tx_input_num, 32'h0B030000);
          chk("t3_stall_out_valid", 32'(out_valid), 0);
          tick();
        end
        stall = 1'b0;
      end
    end
    req_valid = '0;
    collect(3, 8);
    chk("t3_err", 32'(err_mismatch), 0);
    chk("t3_inflight_end", 32'(inflight), 0);
    // Spurious transmitter output with an empty tag pipeline.
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("t4_err_set", 32'(err_mismatch), 1);
    chk("t4_out_valid", 32'(out_valid), 0);
    repeat (3) tick();
    chk("t4_err_sticky", 32'(err_mismatch), 1);
    // Six samples in flight then an asynchronous reset.
    for (int k = 0; k < 6; k++) begin
      req_valid = 4'b0001;
      #1;
      chk("t5_single_grant", 32'(req_ready), 32'h1);
      tick();
    end
    req_valid = '0;
    tick();
    chk("t5_inflight6", 32'(inflight), 6);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_rst_inflight", 32'(inflight), 0);
    chk("t5_rst_in_valid", 32'(tx_input_valid), 0);
    chk("t5_rst_in_num", tx_input_num, 0);
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    chk("t5_rst_out_num", 32'(out_num), 0);
    chk("t5_rst_err", 32'(err_mismatch), 0);
    tick();
    resetn = 1'b1;
    req_valid = 4'b1100;
    #1;
    chk("t5_ptr_restart", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    repeat (20) tick();
    chk("t5_err_clean", 32'(err_mismatch), 0);
    // All valid, then requester 0 dropped.
    do_reset();
`ifdef TX_ARB_PRIORITY_EN
    g6 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
`else
    g6 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
`endif
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 4) ? 4'b1111 : 4'b1110;
      #1;
      chk("t6_grant", 32'(req_ready), 32'(g6[k]));
      tick();
    end
    req_valid = '0;
    repeat (20) tick();
    chk("t6_inflight_end", 32'(inflight), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
